// File: rtl/csr_uart_tx_pkg.sv
// Shared definitions for the CSR-mapped UART transmitter: CSR address,
// modify-code encodings, serializer state encoding and status word layout.
package csr_uart_tx_pkg;

  localparam logic [11:0] CSR_UART_ADDR = 12'hBC0;

  // CSR modify codes; 4..7 are reserved and ignored by this unit.
  typedef enum logic [2:0] {
    MOD_NONE  = 3'd0,
    MOD_WRITE = 3'd1,
    MOD_SET   = 3'd2,
    MOD_CLEAR = 3'd3
  } csr_modify_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Read-back word: {21'b0, overflow, busy, full, 8'b0}
  typedef struct packed {
    logic [20:0] rsvd;
    logic        overflow;
    logic        busy;
    logic        full;
    logic [7:0]  data;
  } uart_status_t;

endpackage

// File: rtl/csr_uart_tx_if.sv
// CSR access bus seen by the UART transmitter. The master drives the
// strobe/address/modify/data; the unit answers with a claim and read data.
interface csr_uart_tx_if;
  logic        read;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid;

  modport master (output read, modify, wdata, addr, input rdata, valid);
  modport slave  (input read, modify, wdata, addr, output rdata, valid);
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read data. A push
// against a full FIFO is still taken when a pop frees a slot in that cycle.
module sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign dout      = r_mem[r_rd];
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= din;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + PW'(1);
      if (w_pop_ok)  r_rd <= r_rd + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/csr_uart_tx.sv
// CSR-mapped UART transmitter: CSR writes queue bytes in a small FIFO, a
// serializer sends 8N1 frames back-to-back, and a status read reports
// overflow/busy/full.
module csr_uart_tx
  import csr_uart_tx_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = CSR_UART_ADDR,
  parameter int          DIVISOR   = 868,
  parameter int          DEPTH     = 4
) (
  input  logic          clk,
  input  logic          rst,
  csr_uart_tx_if.slave  bus,
  output logic          tx
);

  localparam int                CW     = $clog2(DIVISOR);
  localparam logic [CW-1:0]     RELOAD = CW'(DIVISOR - 1);
  localparam int                FCW    = $clog2(DEPTH) + 1;

  // CSR front end
  logic [11:0]  r_q_addr;
  logic         r_read;
  logic         r_ovf;
  logic         w_sel;
  logic         w_push;
  logic         w_ovf_set;
  uart_status_t w_status;

  // FIFO
  logic           w_pop;
  logic [7:0]     w_dout;
  logic           w_empty;
  logic           w_full;
  logic [FCW-1:0] w_count;

  // Serializer
  uart_state_e r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;

  logic w_unused;
  assign w_unused = ^{bus.wdata[31:8], w_full};

  assign w_sel     = (r_q_addr == BASE_ADDR);
  assign w_push    = w_sel && (bus.modify == MOD_WRITE);
  assign w_ovf_set = w_push && (w_count == FCW'(DEPTH)) && !w_pop;
  assign bus.valid = r_read && w_sel && !rst;
  assign tx        = r_tx;

  // Status word assembly; only driven onto the OR-bus when claimed.
  always_comb begin
    w_status          = '0;
    w_status.overflow = r_ovf;
    w_status.busy     = !w_empty || (r_state != ST_IDLE);
    w_status.full     = (w_count == FCW'(DEPTH));
    bus.rdata         = bus.valid ? w_status : '0;
  end

  // Address/read pipeline and sticky overflow (cleared once it has been read).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_addr <= '0;
      r_read   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_q_addr <= bus.addr;
      r_read   <= bus.read;
      r_ovf    <= (r_ovf && !bus.valid) || w_ovf_set;
    end
  end

  sync_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.wdata[7:0]),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  // Serializer state register; tx is a flop so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Next-state: each bit holds DIVISOR cycles via the down-counter; the next
  // tx level is chosen together with the transition so it lands on time.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_dout;
          w_cnt_nxt   = RELOAD;
          w_tx_nxt    = 1'b0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = RELOAD;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_DATA: begin
        if (r_cnt == '0) begin
          w_cnt_nxt = RELOAD;
          if (r_bit == 3'd7) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_STOP: begin
        if (r_cnt == '0) begin
          if (!w_empty) begin
            // Chain straight into the next start bit: no idle gap.
            w_pop       = 1'b1;
            w_shift_nxt = w_dout;
            w_cnt_nxt   = RELOAD;
            w_tx_nxt    = 1'b0;
            w_state_nxt = ST_START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_uart_tx.sv
// Bench for csr_uart_tx: a frame-timeline/queue model checked every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_csr_uart_tx;

  localparam logic [11:0] BASE = 12'hBC0;
  localparam int          D    = 4;
  localparam int          DEP  = 4;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  csr_uart_tx_if bus();

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csr_uart_tx #(.BASE_ADDR(BASE), .DIVISOR(D), .DEPTH(DEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx)
  );

  // ---------------- behavioural model ----------------
  logic [7:0]  mq[$];
  logic [7:0]  m_byte = 8'h00;
  bit          m_act  = 1'b0;
  int          m_t    = 0;
  logic [11:0] m_qa   = '0;
  logic        m_rd   = 1'b0;
  logic        m_ovf  = 1'b0;
  bit          m_init = 1'b0;

  // Line level at offset t into a frame of byte b: start, 8 data LSB first, stop.
  function automatic logic frame_bit(input int t, input logic [7:0] b);
    if (t < D) return 1'b0;
    if (t < 9 * D) return b[(t - D) / D];
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_act = 1'b0; m_t = 0; m_ovf = 1'b0; m_qa = '0; m_rd = 1'b0;
    end else begin
      bit sel, v, fin, pop, push, acc;
      sel  = (m_qa == BASE);
      v    = m_rd && sel;
      fin  = m_act && (m_t == 10 * D - 1);
      pop  = (!m_act || fin) && (mq.size() > 0);
      push = sel && (bus.modify == 3'd1);
      acc  = push && ((mq.size() < DEP) || pop);
      if (pop) begin
        m_byte = mq.pop_front(); m_act = 1'b1; m_t = 0;
      end else if (fin) m_act = 1'b0;
      else if (m_act) m_t++;
      if (acc) mq.push_back(bus.wdata[7:0]);
      m_ovf = (m_ovf && !v) || (push && !acc);
      m_qa  = bus.addr;
      m_rd  = bus.read;
    end
    m_init = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      logic       ev, et;
      logic [31:0] er;
      ev = m_rd && (m_qa == BASE) && !rst;
      er = ev ? {21'b0, m_ovf, (m_act || mq.size() > 0), (mq.size() == DEP), 8'b0} : 32'h0;
      et = m_act ? frame_bit(m_t, m_byte) : 1'b1;
      chk("model_tx", {31'b0, tx}, {31'b0, et});
      chk("model_valid", {31'b0, bus.valid}, {31'b0, ev});
      chk("model_rdata", bus.rdata, er);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drv(input logic r, input logic [2:0] m, input logic [31:0] wd,
                     input logic [11:0] a, input logic rs);
    @(posedge clk); #1;
    rst = rs; bus.read = r; bus.modify = m; bus.wdata = wd; bus.addr = a;
  endtask

  task automatic idle(input int n, input logic [11:0] a);
    repeat (n) drv(1'b0, 3'd0, 32'h0, a, 1'b0);
  endtask

  initial begin
    int b55[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    rst = 1'b1; bus.read = 1'b0; bus.modify = 3'd0; bus.wdata = '0; bus.addr = '0;
    repeat (3) drv(1'b0, 3'd0, 32'h0, 12'h0, 1'b1);
    @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 32'h1);
    chk("rst_valid", {31'b0, bus.valid}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    idle(2, 12'h0);

    // Single frame of 0x55: literal waveform, k = cycles after the write.
    idle(1, BASE);
    drv(1'b0, 3'd1, 32'h55, 12'h0, 1'b0);
    for (int k = 1; k <= 44; k++) begin
      logic e;
      idle(1, 12'h0);
      @(negedge clk);
      if (k < 2) e = 1'b1;
      else if (k <= 5) e = 1'b0;
      else if (k <= 37) e = b55[(k - 6) / 4][0];
      else e = 1'b1;
      chk("f55_tx", {31'b0, tx}, {31'b0, e});
    end

    // Set/clear/reserved codes, and a write to another address: nothing sent.
    idle(1, BASE);
    drv(1'b0, 3'd2, 32'hAA, BASE, 1'b0);
    drv(1'b0, 3'd3, 32'hAA, BASE, 1'b0);
    drv(1'b0, 3'd5, 32'hAA, 12'hBC2, 1'b0);
    drv(1'b0, 3'd1, 32'hAA, 12'h0, 1'b0);
    drv(1'b1, 3'd0, 32'h0, BASE, 1'b0);
    idle(1, 12'h0);
    @(negedge clk);
    chk("nowr_valid", {31'b0, bus.valid}, 32'h1);
    chk("nowr_rdata", bus.rdata, 32'h0);
    for (int k = 0; k < 6; k++) begin
      idle(1, 12'h0);
      @(negedge clk);
      chk("nowr_tx", {31'b0, tx}, 32'h1);
    end

    // Six back-to-back writes: the sixth overflows.
    idle(1, BASE);
    for (int i = 1; i <= 6; i++) drv(1'b0, 3'd1, i, BASE, 1'b0);
    drv(1'b1, 3'd0, 32'h0, BASE, 1'b0);
    drv(1'b1, 3'd0, 32'h0, BASE, 1'b0);
    @(negedge clk);
    chk("ovf_rd1", bus.rdata, 32'h700);
    drv(1'b1, 3'd0, 32'h0, 12'hBC1, 1'b0);
    @(negedge clk);
    chk("ovf_rd2", bus.rdata, 32'h300);
    chk("ovf_rd2_valid", {31'b0, bus.valid}, 32'h1);
    idle(1, 12'h0);
    @(negedge clk);
    chk("other_addr_valid", {31'b0, bus.valid}, 32'h0);
    chk("other_addr_rdata", bus.rdata, 32'h0);
    idle(210, 12'h0);
    drv(1'b1, 3'd0, 32'h0, BASE, 1'b0);
    idle(1, 12'h0);
    @(negedge clk);
    chk("drain_rdata", bus.rdata, 32'h0);

    // Push into a full FIFO in the very cycle the stop bit pops it.
    idle(1, BASE);
    for (int i = 0; i < 5; i++) drv(1'b0, 3'd1, 32'h11 + i, BASE, 1'b0);
    idle(34, BASE);
    drv(1'b1, 3'd0, 32'h0, BASE, 1'b0);
    idle(1, BASE);
    @(negedge clk);
    chk("full_before", bus.rdata, 32'h300);
    drv(1'b0, 3'd1, 32'h16, BASE, 1'b0);
    drv(1'b1, 3'd0, 32'h0, BASE, 1'b0);
    idle(1, 12'h0);
    @(negedge clk);
    chk("pop_push_rdata", bus.rdata, 32'h300);
    idle(230, 12'h0);
    drv(1'b1, 3'd0, 32'h0, BASE, 1'b0);
    idle(1, 12'h0);
    @(negedge clk);
    chk("pop_push_drain", bus.rdata, 32'h0);

    // Reset in the middle of a data bit with two bytes queued.
    idle(1, BASE);
    drv(1'b0, 3'd1, 32'hA1, BASE, 1'b0);
    drv(1'b0, 3'd1, 32'hA2, BASE, 1'b0);
    drv(1'b0, 3'd1, 32'hA3, 12'h0, 1'b0);
    idle(7, 12'h0);
    drv(1'b0, 3'd0, 32'h0, 12'h0, 1'b1);
    idle(1, 12'h0);
    @(negedge clk);
    chk("abort_tx", {31'b0, tx}, 32'h1);
    drv(1'b1, 3'd0, 32'h0, BASE, 1'b0);
    idle(1, 12'h0);
    @(negedge clk);
    chk("abort_valid", {31'b0, bus.valid}, 32'h1);
    chk("abort_rdata", bus.rdata, 32'h0);
    for (int k = 0; k < 100; k++) begin
      idle(1, 12'h0);
      @(negedge clk);
      chk("abort_idle_tx", {31'b0, tx}, 32'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
